// File: rtl/div_unit.sv
// div_unit: iterative 32-bit signed/unsigned restoring divider for DIV/DIVU
// in the EX stage. It holds the pipeline via stall_o while it iterates and
// writes {remainder, quotient} toward HI/LO.
//
// Ports:
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   start_i   in   DIV/DIVU present in E (held while it sits there)
//   signed_i  in   1 = DIV, 0 = DIVU
//   opa_i     in   dividend (rs), sampled at accept
//   opb_i     in   divisor (rt), sampled at accept
//   annul_i   in   flush/exception cancel, aborts any operation
//   stall_o   out  stall request to the hazard unit (combinational)
//   ready_o   out  one-cycle pulse, result_o valid
//   result_o  out  {remainder -> HI, quotient -> LO}
//   dz_o      out  divide-by-zero flag, pulsed with ready_o
//
// Build option: define DIV_ZERO_FAST_EN to finish a zero-divisor divide in
// one cycle with {dividend, 32'hFFFFFFFF} and a dz_o pulse. Without it a zero
// divisor runs the full iteration and dz_o is tied low.

module div_unit #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        annul_i,
    output logic        stall_o,
    output logic        ready_o,
    output logic [63:0] result_o,
    output logic        dz_o
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [W-1:0]   r_rem;
    logic [W-1:0]   r_quo;
    logic [W-1:0]   r_div;
    logic [CW-1:0]  r_cnt;
    logic           r_qneg;
    logic           r_rneg;
    logic           r_ready;
    logic [2*W-1:0] r_result;

    logic           w_accept;
    logic           w_last;
    logic [W-1:0]   w_abs_a;
    logic [W-1:0]   w_abs_b;
    logic [W:0]     w_shift;
    logic           w_ge;
    logic [W-1:0]   w_rem_step;
    logic [W-1:0]   w_quo_step;
    logic [W-1:0]   w_rem_fix;
    logic [W-1:0]   w_quo_fix;

    // Operand magnitudes; -0x80000000 wraps to 0x80000000, which is the
    // correct unsigned magnitude.
    assign w_abs_a = (signed_i && opa_i[W-1]) ? (~opa_i + W'(1)) : opa_i;
    assign w_abs_b = (signed_i && opb_i[W-1]) ? (~opb_i + W'(1)) : opb_i;

    assign w_accept = (r_state == S_IDLE) && start_i && !annul_i;
    assign w_last   = (r_cnt == CW'(ITER - 1));

    // One restoring step on the 33-bit shifted partial remainder.
    assign w_shift    = {r_rem, r_quo[W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_div});
    assign w_rem_step = w_ge ? W'(w_shift - {1'b0, r_div}) : w_shift[W-1:0];
    assign w_quo_step = {r_quo[W-2:0], w_ge};

    // Sign fix applied to the final step as it is registered into result_o.
    assign w_quo_fix = r_qneg ? (~w_quo_step + W'(1)) : w_quo_step;
    assign w_rem_fix = r_rneg ? (~w_rem_step + W'(1)) : w_rem_step;

    // Stall is combinational so the accept cycle itself holds the pipeline.
    assign stall_o = !rst && !annul_i &&
                     (((r_state == S_IDLE) && start_i) || (r_state == S_BUSY));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (annul_i) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
`ifdef DIV_ZERO_FAST_EN
                        w_next = (opb_i == '0) ? S_DONE : S_BUSY;
`else
                        w_next = S_BUSY;
`endif
                    end
                end
                S_BUSY: begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end
                end
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Datapath and registered outputs; result is captured on entry to DONE
    // so ready_o/result_o are visible during the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_ready  <= 1'b0;
            r_result <= '0;
        end else begin
            r_ready <= 1'b0;
            if (w_accept) begin
                r_rem  <= '0;
                r_quo  <= w_abs_a;
                r_div  <= w_abs_b;
                r_cnt  <= '0;
                r_qneg <= signed_i & (opa_i[W-1] ^ opb_i[W-1]);
                r_rneg <= signed_i & opa_i[W-1];
            end else if (r_state == S_BUSY) begin
                r_rem <= w_rem_step;
                r_quo <= w_quo_step;
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_next == S_DONE) begin
                r_ready <= 1'b1;
                if (r_state == S_IDLE) begin
                    r_result <= {opa_i, {W{1'b1}}};
                end else begin
                    r_result <= {w_rem_fix, w_quo_fix};
                end
            end
        end
    end

`ifdef DIV_ZERO_FAST_EN
    logic r_dz;

    // Zero-divisor fast path: the only way to reach DONE straight from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dz <= 1'b0;
        end else begin
            r_dz <= (r_state == S_IDLE) && (w_next == S_DONE);
        end
    end

    assign dz_o = r_dz;
`else
    assign dz_o = 1'b0;
`endif

    assign ready_o  = r_ready;
    assign result_o = r_result;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus hand-written sequences for annul,
// back-to-back and reset-mid-operation behaviour of div_unit.

module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        annul_i;
    logic        stall_o;
    logic        ready_o;
    logic [63:0] result_o;
    logic        dz_o;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.ITER(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .signed_i (signed_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .annul_i  (annul_i),
        .stall_o  (stall_o),
        .ready_o  (ready_o),
        .result_o (result_o),
        .dz_o     (dz_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] res;
        int          rdy;
        int          stalls;
        logic        dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is positioned just after a posedge; that cycle is cycle 0.
    // Returns ready cycle (-1 if none within budget) and stall-cycle count.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int rdy, output int stalls,
                          output logic [63:0] res, output logic dz);
        logic st;
        start_i  = 1'b1;
        signed_i = s;
        opa_i    = a;
        opb_i    = b;
        rdy      = -1;
        stalls   = 0;
        res      = '0;
        dz       = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            st = stall_o;
            if (st) stalls++;
            if (ready_o && rdy < 0) begin
                rdy = c;
                res = result_o;
                dz  = dz_o;
            end
            @(posedge clk);
            #1;
            if (!st) start_i = 1'b0;
            if (rdy >= 0) break;
        end
        start_i = 1'b0;
    endtask

    vec_t        vecs[10];
    int          rdy;
    int          rdy2;
    int          stalls;
    logic [63:0] res;
    logic        dz;
    int          zrdy;
    int          zstall;
    logic        zdz;
    int          seen;

    initial begin
`ifdef DIV_ZERO_FAST_EN
        zrdy = 1;  zstall = 1;  zdz = 1'b1;
`else
        zrdy = 33; zstall = 33; zdz = 1'b0;
`endif
        vecs[0] = '{32'd100,        32'd7,          1'b0, {32'd2, 32'd14},                 33, 33, 1'b0};
        vecs[1] = '{32'hFFFFFFF9,   32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD},    33, 33, 1'b0};
        vecs[2] = '{32'd7,          32'hFFFFFFFE,   1'b1, {32'h00000001, 32'hFFFFFFFD},    33, 33, 1'b0};
        vecs[3] = '{32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h00000000, 32'h80000000},    33, 33, 1'b0};
        vecs[4] = '{32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, {32'hFFFFFFFE, 32'd14},          33, 33, 1'b0};
        vecs[5] = '{32'hFFFFFFFF,   32'd1,          1'b0, {32'd0, 32'hFFFFFFFF},           33, 33, 1'b0};
        vecs[6] = '{32'h80000000,   32'h80000000,   1'b0, {32'd0, 32'd1},                  33, 33, 1'b0};
        vecs[7] = '{32'd0,          32'd5,          1'b0, {32'd0, 32'd0},                  33, 33, 1'b0};
        vecs[8] = '{32'd5,          32'd0,          1'b0, {32'd5, 32'hFFFFFFFF},           zrdy, zstall, zdz};
        vecs[9] = '{32'd1000,       32'd33,         1'b0, {32'd10, 32'd30},                33, 33, 1'b0};

        rst = 1'b1; start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd1; opb_i = 32'd1; annul_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 64'(stall_o), 64'd0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_dz", 64'(dz_o), 64'd0);
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].s, rdy, stalls, res, dz);
            check($sformatf("v%0d_result", i), res, vecs[i].res);
            check($sformatf("v%0d_ready_cycle", i), 64'(rdy), 64'(vecs[i].rdy));
            check($sformatf("v%0d_stall_cycles", i), 64'(stalls), 64'(vecs[i].stalls));
            check($sformatf("v%0d_dz", i), 64'(dz), 64'(vecs[i].dz));
            @(posedge clk); #1;
        end

        // Back-to-back: second start accepted on the cycle after DONE (34).
        do_div(32'd9, 32'd2, 1'b0, rdy, stalls, res, dz);
        check("b2b_first_result", res, {32'd1, 32'd4});
        check("b2b_first_ready", 64'(rdy), 64'd33);
        do_div(32'd20, 32'd6, 1'b0, rdy2, stalls, res, dz);
        check("b2b_second_result", res, {32'd2, 32'd3});
        check("b2b_second_ready_abs", 64'(rdy + 1 + rdy2), 64'd67);

        // Annul at cycle 10 of DIVU 50/3; restart at cycle 11.
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd50; opb_i = 32'd3;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready_o) seen++;
            @(posedge clk); #1;
        end
        annul_i = 1'b1;
        @(negedge clk);
        if (ready_o) seen++;
        check("annul_stall", 64'(stall_o), 64'd0);
        check("annul_result_held", result_o, {32'd2, 32'd3});
        @(posedge clk); #1;
        annul_i = 1'b0;
        @(negedge clk);
        check("annul_restart_stall", 64'(stall_o), 64'd1);
        check("annul_no_ready", 64'(seen + 32'(ready_o)), 64'd0);
        @(posedge clk); #1;
        // Restart seen accepted above; run it through (cycle 1 onward).
        rdy = -1;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (ready_o && rdy < 0) begin
                rdy = c;
                res = result_o;
            end
            @(posedge clk); #1;
            if (rdy >= 0) break;
        end
        start_i = 1'b0;
        check("annul_restart_ready", 64'(rdy), 64'd33);
        check("annul_restart_result", res, {32'd2, 32'd16});

        // Reset at cycle 15 of a divide.
        @(posedge clk); #1;
        start_i = 1'b1; opa_i = 32'd1000; opb_i = 32'd10;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("midrst_stall", 64'(stall_o), 64'd0);
        check("midrst_ready", 64'(ready_o), 64'd0);
        check("midrst_result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        check("midrst_no_ready", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
